bp_be_issue_pair_di: RTL and testbench

BP_BE_ISSUE_PAIR_DI -- requirements
Module: bp_be_issue_pair_di

---
 rtl/bp_be_issue_pair_di.sv | 145 ++++++++++++++
 tb/tb_bp_be_issue_pair_di.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_issue_pair_di.sv
// Two-slot in-order dual-issue buffer between the decoder and the dispatch stage.
// Holds up to one pair and issues the oldest instructions first, gated by scoreboard hazards.
module bp_be_issue_pair_di #(
    parameter int num_rs_p    = 2,
    parameter int pkt_width_p = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     pair_v_i,
    output logic                     pair_ready_o,
    input  logic                     slot1_v_i,

    input  logic [pkt_width_p-1:0]   pkt0_i,
    input  logic [num_rs_p*5-1:0]    rs0_i,
    input  logic [num_rs_p-1:0]      rs0_v_i,
    input  logic [4:0]               rd0_i,
    input  logic                     rd0_w_v_i,
    input  logic                     long0_i,
    input  logic                     mem0_i,

    input  logic [pkt_width_p-1:0]   pkt1_i,
    input  logic [num_rs_p*5-1:0]    rs1_i,
    input  logic [num_rs_p-1:0]      rs1_v_i,
    input  logic [4:0]               rd1_i,
    input  logic                     rd1_w_v_i,
    input  logic                     long1_i,
    input  logic                     mem1_i,

    output logic [num_rs_p*5-1:0]    sb_rs_o1,
    output logic [num_rs_p*5-1:0]    sb_rs_o2,
    output logic [4:0]               sb_rd_o1,
    output logic [4:0]               sb_rd_o2,
    input  logic [num_rs_p-1:0]      sb_rs_match_i1,
    input  logic [num_rs_p-1:0]      sb_rs_match_i2,
    input  logic                     sb_rd_match_i1,
    input  logic                     sb_rd_match_i2,

    output logic                     score_v_o,
    output logic [4:0]               score_rd_o,
    output logic                     score_v_o2,
    output logic [4:0]               score_rd_o2,

    input  logic                     dispatch_ready_i,
    output logic                     issue_v_o1,
    output logic                     issue_v_o2,
    output logic [pkt_width_p-1:0]   issue_pkt_o1,
    output logic [pkt_width_p-1:0]   issue_pkt_o2,

    input  logic                     flush_i
);

    localparam int reg_addr_width_gp = 5;
    localparam int rs_width_lp       = num_rs_p * reg_addr_width_gp;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SINGLE = 2'd1,
        PAIR   = 2'd2
    } state_e;

    typedef struct packed {
        logic [pkt_width_p-1:0]       pkt;
        logic [rs_width_lp-1:0]       rs;
        logic [num_rs_p-1:0]          rs_v;
        logic [reg_addr_width_gp-1:0] rd;
        logic                         rd_w_v;
        logic                         long_lat;
        logic                         mem;
    } slot_s;

    state_e state_r, state_n;
    slot_s  slot0_r, slot1_r, slot0_n, slot1_n;
    slot_s  in_slot0, in_slot1;

    logic s0_v, s1_v;
    logic hazard0, hazard1;
    logic issue0, issue1;
    logic all_issued;
    logic accept;

    assign in_slot0 = {pkt0_i, rs0_i, rs0_v_i, rd0_i, rd0_w_v_i, long0_i, mem0_i};
    assign in_slot1 = {pkt1_i, rs1_i, rs1_v_i, rd1_i, rd1_w_v_i, long1_i, mem1_i};

    assign s0_v = (state_r != EMPTY);
    assign s1_v = (state_r == PAIR);

    // Slot-1 scoreboard results already account for the slot-0 destination.
    assign hazard0 = (|(sb_rs_match_i1 & slot0_r.rs_v)) | (sb_rd_match_i1 & slot0_r.rd_w_v);
    assign hazard1 = (|(sb_rs_match_i2 & slot1_r.rs_v)) | (sb_rd_match_i2 & slot1_r.rd_w_v);

    assign issue0 = !reset_i & s0_v & dispatch_ready_i & !hazard0 & !flush_i;
    assign issue1 = issue0 & s1_v & !hazard1 & !(slot0_r.mem & slot1_r.mem);

    assign all_issued   = ((state_r == SINGLE) & issue0) | ((state_r == PAIR) & issue1);
    assign pair_ready_o = !reset_i & ((state_r == EMPTY) | all_issued | flush_i);
    assign accept       = pair_v_i & pair_ready_o;

    assign issue_v_o1   = issue0;
    assign issue_v_o2   = issue1;
    assign issue_pkt_o1 = slot0_r.pkt;
    assign issue_pkt_o2 = slot1_r.pkt;

    assign sb_rs_o1 = slot0_r.rs;
    assign sb_rs_o2 = slot1_r.rs;
    assign sb_rd_o1 = slot0_r.rd;
    assign sb_rd_o2 = slot1_r.rd;

    assign score_v_o   = issue0 & slot0_r.long_lat & slot0_r.rd_w_v & (slot0_r.rd != '0);
    assign score_v_o2  = issue1 & slot1_r.long_lat & slot1_r.rd_w_v & (slot1_r.rd != '0);
    assign score_rd_o  = slot0_r.rd;
    assign score_rd_o2 = slot1_r.rd;

    // Accept is only possible once every held slot drains or is flushed, so loading never drops work.
    always_comb begin
        state_n = state_r;
        slot0_n = slot0_r;
        slot1_n = slot1_r;
        if (accept) begin
            slot0_n = in_slot0;
            slot1_n = in_slot1;
            state_n = slot1_v_i ? PAIR : SINGLE;
        end else if (flush_i) begin
            state_n = EMPTY;
        end else if ((state_r == PAIR) && issue0 && !issue1) begin
            slot0_n = slot1_r;
            state_n = SINGLE;
        end else if (all_issued) begin
            state_n = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= EMPTY;
            slot0_r <= '0;
            slot1_r <= '0;
        end else begin
            state_r <= state_n;
            slot0_r <= slot0_n;
            slot1_r <= slot1_n;
        end
    end

endmodule

// File: tb/tb_bp_be_issue_pair_di.sv
// Self-checking bench for bp_be_issue_pair_di: directed scenarios plus a randomized run
// against a queue-based model of the held instruction window.
module tb_bp_be_issue_pair_di;

    typedef struct packed {
        logic [63:0] pkt;
        logic [9:0]  rs;
        logic [1:0]  rs_v;
        logic [4:0]  rd;
        logic        wv;
        logic        lng;
        logic        mem;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        pair_v_i, pair_ready_o, slot1_v_i;
    logic [63:0] pkt0_i, pkt1_i;
    logic [9:0]  rs0_i, rs1_i;
    logic [1:0]  rs0_v_i, rs1_v_i;
    logic [4:0]  rd0_i, rd1_i;
    logic        rd0_w_v_i, rd1_w_v_i, long0_i, long1_i, mem0_i, mem1_i;
    logic [9:0]  sb_rs_o1, sb_rs_o2;
    logic [4:0]  sb_rd_o1, sb_rd_o2;
    logic [1:0]  sb_rs_match_i1, sb_rs_match_i2;
    logic        sb_rd_match_i1, sb_rd_match_i2;
    logic        score_v_o, score_v_o2;
    logic [4:0]  score_rd_o, score_rd_o2;
    logic        dispatch_ready_i;
    logic        issue_v_o1, issue_v_o2;
    logic [63:0] issue_pkt_o1, issue_pkt_o2;
    logic        flush_i;

    int tests = 0;
    int fails = 0;

    bp_be_issue_pair_di #(.num_rs_p(2), .pkt_width_p(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pair_v_i(pair_v_i), .pair_ready_o(pair_ready_o), .slot1_v_i(slot1_v_i),
        .pkt0_i(pkt0_i), .rs0_i(rs0_i), .rs0_v_i(rs0_v_i), .rd0_i(rd0_i),
        .rd0_w_v_i(rd0_w_v_i), .long0_i(long0_i), .mem0_i(mem0_i),
        .pkt1_i(pkt1_i), .rs1_i(rs1_i), .rs1_v_i(rs1_v_i), .rd1_i(rd1_i),
        .rd1_w_v_i(rd1_w_v_i), .long1_i(long1_i), .mem1_i(mem1_i),
        .sb_rs_o1(sb_rs_o1), .sb_rs_o2(sb_rs_o2), .sb_rd_o1(sb_rd_o1), .sb_rd_o2(sb_rd_o2),
        .sb_rs_match_i1(sb_rs_match_i1), .sb_rs_match_i2(sb_rs_match_i2),
        .sb_rd_match_i1(sb_rd_match_i1), .sb_rd_match_i2(sb_rd_match_i2),
        .score_v_o(score_v_o), .score_rd_o(score_rd_o),
        .score_v_o2(score_v_o2), .score_rd_o2(score_rd_o2),
        .dispatch_ready_i(dispatch_ready_i),
        .issue_v_o1(issue_v_o1), .issue_v_o2(issue_v_o2),
        .issue_pkt_o1(issue_pkt_o1), .issue_pkt_o2(issue_pkt_o2),
        .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic instr_t mk_instr(input logic [63:0] pkt, input logic [4:0] rs_hi,
                                        input logic [4:0] rs_lo, input logic [4:0] rd,
                                        input logic lng, input logic mem);
        instr_t t;
        t.pkt = pkt; t.rs = {rs_hi, rs_lo}; t.rs_v = 2'b11; t.rd = rd;
        t.wv = 1'b1; t.lng = lng; t.mem = mem;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.pkt  = {$urandom, $urandom};
        t.rs   = 10'($urandom);
        t.rs_v = 2'($urandom);
        t.rd   = 5'($urandom_range(0, 7));
        t.wv   = ($urandom_range(0, 3) != 0);
        t.lng  = 1'($urandom);
        t.mem  = ($urandom_range(0, 2) == 0);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_idle();
        pair_v_i = 0; slot1_v_i = 0;
        pkt0_i = '0; rs0_i = '0; rs0_v_i = '0; rd0_i = '0; rd0_w_v_i = 0; long0_i = 0; mem0_i = 0;
        pkt1_i = '0; rs1_i = '0; rs1_v_i = '0; rd1_i = '0; rd1_w_v_i = 0; long1_i = 0; mem1_i = 0;
        sb_rs_match_i1 = '0; sb_rs_match_i2 = '0; sb_rd_match_i1 = 0; sb_rd_match_i2 = 0;
        dispatch_ready_i = 1; flush_i = 0;
    endtask

    task automatic set_pair(input instr_t a, input instr_t b, input logic two);
        pair_v_i = 1; slot1_v_i = two;
        pkt0_i = a.pkt; rs0_i = a.rs; rs0_v_i = a.rs_v; rd0_i = a.rd;
        rd0_w_v_i = a.wv; long0_i = a.lng; mem0_i = a.mem;
        pkt1_i = b.pkt; rs1_i = b.rs; rs1_v_i = b.rs_v; rd1_i = b.rd;
        rd1_w_v_i = b.wv; long1_i = b.lng; mem1_i = b.mem;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_i = 1;
        @(negedge clk_i);
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_during got %b want 00000",
                     {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
        reset_i = 0;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL reset_after got %b want 10000",
                     {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        instr_t a, b, c, d;
        a = mk_instr(64'hA0, 5'd2, 5'd1, 5'd5, 0, 0);
        b = mk_instr(64'hB1, 5'd4, 5'd3, 5'd6, 0, 0);
        c = mk_instr(64'hC2, 5'd9, 5'd8, 5'd10, 0, 0);
        d = mk_instr(64'hD3, 5'd12, 5'd11, 5'd13, 0, 0);
        drive_idle();
        set_pair(a, b, 1);
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL accept_no_issue got %b want 100", {pair_ready_o, issue_v_o1, issue_v_o2});
        end
        tick();
        set_pair(c, d, 1);
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, issue_pkt_o1, issue_pkt_o2} !== {3'b111, a.pkt, b.pkt}) begin
            fails++;
            $display("[TB] FAIL indep_pair got %b %h %h want 111 %h %h",
                     {pair_ready_o, issue_v_o1, issue_v_o2}, issue_pkt_o1, issue_pkt_o2, a.pkt, b.pkt);
        end
        tick();
        drive_idle();
        #1;
        tests++;
        if ({issue_v_o1, issue_v_o2, issue_pkt_o1, issue_pkt_o2} !== {2'b11, c.pkt, d.pkt}) begin
            fails++;
            $display("[TB] FAIL back_to_back got %b %h %h want 11 %h %h",
                     {issue_v_o1, issue_v_o2}, issue_pkt_o1, issue_pkt_o2, c.pkt, d.pkt);
        end
        tick();
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL drained_empty got %b want 100", {pair_ready_o, issue_v_o1, issue_v_o2});
        end
    endtask

    task automatic test_slot1_dep();
        instr_t a, b;
        a = mk_instr(64'h1111, 5'd2, 5'd1, 5'd5, 0, 0);
        b = mk_instr(64'h2222, 5'd3, 5'd5, 5'd6, 0, 0);
        drive_idle();
        set_pair(a, b, 1);
        tick();
        drive_idle();
        sb_rs_match_i2 = 2'b01;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, issue_pkt_o1} !== {3'b010, a.pkt}) begin
            fails++;
            $display("[TB] FAIL dep_slot0_only got %b %h want 010 %h",
                     {pair_ready_o, issue_v_o1, issue_v_o2}, issue_pkt_o1, a.pkt);
        end
        tick();
        sb_rs_match_i2 = 2'b00;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, issue_pkt_o1, sb_rs_o1, sb_rd_o1}
                !== {3'b110, b.pkt, b.rs, b.rd}) begin
            fails++;
            $display("[TB] FAIL dep_shifted got %b %h %h %h want 110 %h %h %h",
                     {pair_ready_o, issue_v_o1, issue_v_o2}, issue_pkt_o1, sb_rs_o1, sb_rd_o1,
                     b.pkt, b.rs, b.rd);
        end
        tick();
    endtask

    task automatic test_mem_pair();
        instr_t a, b;
        a = mk_instr(64'h3333, 5'd2, 5'd1, 5'd5, 0, 1);
        b = mk_instr(64'h4444, 5'd4, 5'd3, 5'd6, 0, 1);
        drive_idle();
        set_pair(a, b, 1);
        tick();
        drive_idle();
        #1;
        tests++;
        if ({issue_v_o1, issue_v_o2, issue_pkt_o1} !== {2'b10, a.pkt}) begin
            fails++;
            $display("[TB] FAIL mem_first got %b %h want 10 %h", {issue_v_o1, issue_v_o2}, issue_pkt_o1, a.pkt);
        end
        tick();
        #1;
        tests++;
        if ({issue_v_o1, issue_v_o2, issue_pkt_o1} !== {2'b10, b.pkt}) begin
            fails++;
            $display("[TB] FAIL mem_second got %b %h want 10 %h", {issue_v_o1, issue_v_o2}, issue_pkt_o1, b.pkt);
        end
        tick();
    endtask

    task automatic test_score();
        instr_t a, b;
        a = mk_instr(64'h5555, 5'd2, 5'd1, 5'd7, 1, 0);
        b = mk_instr(64'h6666, 5'd4, 5'd3, 5'd0, 1, 0);
        drive_idle();
        set_pair(a, b, 1);
        tick();
        drive_idle();
        #1;
        tests++;
        if ({issue_v_o1, issue_v_o2, score_v_o, score_rd_o, score_v_o2} !== {3'b111, 5'd7, 1'b0}) begin
            fails++;
            $display("[TB] FAIL score_x7 got %b rd=%0d v2=%b want 111 rd=7 v2=0",
                     {issue_v_o1, issue_v_o2, score_v_o}, score_rd_o, score_v_o2);
        end
        tick();
        set_pair(b, a, 0);
        tick();
        drive_idle();
        #1;
        tests++;
        if ({issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 4'b1000) begin
            fails++;
            $display("[TB] FAIL score_x0 got %b want 1000", {issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
    endtask

    task automatic test_stall_flush();
        instr_t a, b;
        a = mk_instr(64'h7777, 5'd2, 5'd1, 5'd8, 1, 0);
        b = mk_instr(64'h8888, 5'd4, 5'd3, 5'd9, 1, 0);
        drive_idle();
        set_pair(a, b, 1);
        tick();
        drive_idle();
        dispatch_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, issue_pkt_o1, issue_pkt_o2}
                    !== {4'b0000, a.pkt, b.pkt}) begin
                fails++;
                $display("[TB] FAIL stall_%0d got %b %h %h want 0000 %h %h", i,
                         {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o}, issue_pkt_o1, issue_pkt_o2,
                         a.pkt, b.pkt);
            end
            tick();
        end
        dispatch_ready_i = 1;
        flush_i = 1;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL flush_cycle got %b want 10000",
                     {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
        flush_i = 0;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL flush_empty got %b want 100", {pair_ready_o, issue_v_o1, issue_v_o2});
        end
    endtask

    task automatic test_reset_mid_pair();
        instr_t a, b;
        a = mk_instr(64'h9999, 5'd2, 5'd1, 5'd10, 1, 0);
        b = mk_instr(64'hAAAA, 5'd4, 5'd3, 5'd11, 1, 0);
        drive_idle();
        set_pair(a, b, 1);
        tick();
        drive_idle();
        reset_i = 1;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL rst_mid_during got %b want 00000",
                     {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
        reset_i = 0;
        #1;
        tests++;
        if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL rst_mid_after got %b want 10000",
                     {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2});
        end
        tick();
    endtask

    // The model is an ordered queue of held instructions; issue pops from the front.
    task automatic test_random();
        instr_t q[$];
        instr_t n0, n1;
        logic   haz0, haz1, e1, e2, sc1, sc2, rdy;
        drive_idle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n0 = rand_instr();
            n1 = rand_instr();
            set_pair(n0, n1, 1'($urandom));
            pair_v_i         = ($urandom_range(0, 9) < 6);
            dispatch_ready_i = ($urandom_range(0, 3) != 0);
            flush_i          = ($urandom_range(0, 19) == 0);
            sb_rs_match_i1   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            sb_rs_match_i2   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            sb_rd_match_i1   = ($urandom_range(0, 5) == 0);
            sb_rd_match_i2   = ($urandom_range(0, 5) == 0);

            haz0 = (q.size() >= 1) && ((|(sb_rs_match_i1 & q[0].rs_v)) || (sb_rd_match_i1 && q[0].wv));
            haz1 = (q.size() >= 2) && ((|(sb_rs_match_i2 & q[1].rs_v)) || (sb_rd_match_i2 && q[1].wv));
            e1  = (q.size() >= 1) && dispatch_ready_i && !haz0 && !flush_i;
            e2  = e1 && (q.size() == 2) && !haz1 && !(q[0].mem && q[1].mem);
            sc1 = e1 && q[0].lng && q[0].wv && (q[0].rd != 5'd0);
            sc2 = e2 && q[1].lng && q[1].wv && (q[1].rd != 5'd0);
            rdy = (q.size() == 0) || (q.size() == 1 && e1) || (q.size() == 2 && e2) || flush_i;

            #1;
            tests++;
            if ({pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2} !== {rdy, e1, e2, sc1, sc2}) begin
                fails++;
                $display("[TB] FAIL rand_ctrl cyc=%0d got %b want %b", cyc,
                         {pair_ready_o, issue_v_o1, issue_v_o2, score_v_o, score_v_o2}, {rdy, e1, e2, sc1, sc2});
            end
            if (q.size() >= 1) begin
                tests++;
                if ({issue_pkt_o1, sb_rs_o1, sb_rd_o1} !== {q[0].pkt, q[0].rs, q[0].rd}) begin
                    fails++;
                    $display("[TB] FAIL rand_slot0 cyc=%0d got %h %h %h want %h %h %h", cyc,
                             issue_pkt_o1, sb_rs_o1, sb_rd_o1, q[0].pkt, q[0].rs, q[0].rd);
                end
            end
            if (q.size() == 2) begin
                tests++;
                if ({issue_pkt_o2, sb_rs_o2, sb_rd_o2} !== {q[1].pkt, q[1].rs, q[1].rd}) begin
                    fails++;
                    $display("[TB] FAIL rand_slot1 cyc=%0d got %h %h %h want %h %h %h", cyc,
                             issue_pkt_o2, sb_rs_o2, sb_rd_o2, q[1].pkt, q[1].rs, q[1].rd);
                end
            end
            if (sc1 || sc2) begin
                tests++;
                if ((sc1 && score_rd_o !== q[0].rd) || (sc2 && score_rd_o2 !== q[1].rd)) begin
                    fails++;
                    $display("[TB] FAIL rand_score_rd cyc=%0d got %0d %0d", cyc, score_rd_o, score_rd_o2);
                end
            end

            if (flush_i) q.delete();
            else if (e2) begin void'(q.pop_front()); void'(q.pop_front()); end
            else if (e1) void'(q.pop_front());
            if (pair_v_i && rdy) begin
                q.push_back(n0);
                if (slot1_v_i) q.push_back(n1);
            end
            tick();
        end
        drive_idle();
        flush_i = 1;
        tick();
        flush_i = 0;
    endtask

    initial begin
        reset_i = 1;
        drive_idle();
        test_reset();
        test_back_to_back();
        test_slot1_dep();
        test_mem_pair();
        test_score();
        test_stall_flush();
        test_reset_mid_pair();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
